// File: rtl/satalnk_rxsync_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// satalnk_rxsync_if : PHY RX stream in, qualified stream and link status out
// Rev 1.0
// ---------------------------------------------------------------------------
interface satalnk_rxsync_if;
  logic        i_rx_valid;
  logic [32:0] i_rx_data;
  logic        i_rx_code_err;
  logic        i_clr_errs;
  logic        o_valid;
  logic [32:0] o_data;
  logic        o_synced;
  logic        o_resync_req;
  logic [15:0] o_err_count;

  modport slave (
    input  i_rx_valid, i_rx_data, i_rx_code_err, i_clr_errs,
    output o_valid, o_data, o_synced, o_resync_req, o_err_count
  );

  modport master (
    output i_rx_valid, i_rx_data, i_rx_code_err, i_clr_errs,
    input  o_valid, o_data, o_synced, o_resync_req, o_err_count
  );
endinterface
`default_nettype wire

// File: rtl/satalnk_rxsync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// satalnk_rxsync : ALIGN hunt/lock, loss monitoring and stream gating (RX clk)
// Rev 1.0
// ---------------------------------------------------------------------------
module satalnk_rxsync #(
  parameter logic [31:0] P_ALIGN        = 32'h7B4A4ABC,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned ERR_LOSS_COUNT = 4,
  parameter int unsigned GOOD_CLEAR     = 16,
  parameter int unsigned LG_TIMEOUT     = 12
) (
  input  wire logic          i_rx_clk,
  input  wire logic          i_reset,
  satalnk_rxsync_if.slave    rx
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LOCKING = 2'd1,
    S_SYNCED  = 2'd2
  } state_t;

  localparam logic [3:0] C_LOCK = 4'(LOCK_COUNT);
  localparam logic [3:0] C_LOSS = 4'(ERR_LOSS_COUNT);
  localparam logic [7:0] C_GOOD = 8'(GOOD_CLEAR);

  state_t                state_q;
  logic [LG_TIMEOUT-1:0] tmo_q;
  logic [3:0]            lock_q;
  logic [3:0]            loss_q;
  logic [7:0]            good_q;
  logic                  valid_q;
  logic [32:0]           data_q;
  logic                  synced_q;
  logic                  resync_q;
  logic [15:0]           errcnt_q;

  logic                  is_err;
  logic                  is_align;
  logic [LG_TIMEOUT-1:0] tmo_d;
  logic                  tmo_wrap;

  always_comb begin
    is_err   = rx.i_rx_code_err;
    is_align = !is_err && (rx.i_rx_data == {1'b1, P_ALIGN});
    tmo_d    = tmo_q + 1'b1;
    tmo_wrap = (tmo_d == '0);
  end

  always_ff @(posedge i_rx_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_HUNT;
      tmo_q    <= '0;
      lock_q   <= '0;
      loss_q   <= '0;
      good_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      synced_q <= 1'b0;
      resync_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      resync_q <= 1'b0;
      valid_q  <= rx.i_rx_valid && (state_q == S_SYNCED) && !is_err;
      if (rx.i_rx_valid) begin
        data_q <= rx.i_rx_data;
      end

      // Clear wins over a same-cycle increment
      if (rx.i_clr_errs) begin
        errcnt_q <= '0;
      end else if (rx.i_rx_valid && (state_q == S_SYNCED) && is_err &&
                   (errcnt_q != 16'hFFFF)) begin
        errcnt_q <= errcnt_q + 16'd1;
      end

      if (rx.i_rx_valid) begin
        case (state_q)
          S_HUNT: begin
            if (is_align) begin
              tmo_q <= '0;
              if (C_LOCK == 4'd1) begin
                state_q  <= S_SYNCED;
                synced_q <= 1'b1;
                lock_q   <= '0;
                loss_q   <= '0;
                good_q   <= '0;
              end else begin
                state_q <= S_LOCKING;
                lock_q  <= 4'd1;
              end
            end else begin
              tmo_q <= tmo_d;
              if (tmo_wrap) begin
                resync_q <= 1'b1;
              end
            end
          end

          S_LOCKING: begin
            if (is_err) begin
              state_q <= S_HUNT;
              lock_q  <= '0;
              tmo_q   <= '0;
            end else if (is_align && ((lock_q + 4'd1) == C_LOCK)) begin
              state_q  <= S_SYNCED;
              synced_q <= 1'b1;
              lock_q   <= '0;
              tmo_q    <= '0;
              loss_q   <= '0;
              good_q   <= '0;
            end else begin
              if (is_align) begin
                lock_q <= lock_q + 4'd1;
              end
              tmo_q <= tmo_d;
              if (tmo_wrap) begin
                state_q  <= S_HUNT;
                lock_q   <= '0;
                resync_q <= 1'b1;
              end
            end
          end

          S_SYNCED: begin
            tmo_q <= is_align ? '0 : tmo_d;
            if (is_err) begin
              good_q <= '0;
              loss_q <= loss_q + 4'd1;
            end else if ((good_q + 8'd1) == C_GOOD) begin
              good_q <= '0;
              loss_q <= '0;
            end else begin
              good_q <= good_q + 8'd1;
            end
            // Error-driven loss and ALIGN starvation both drop straight to hunt
            if ((is_err && ((loss_q + 4'd1) == C_LOSS)) || (!is_align && tmo_wrap)) begin
              state_q  <= S_HUNT;
              synced_q <= 1'b0;
              loss_q   <= '0;
              good_q   <= '0;
              tmo_q    <= '0;
            end
          end

          default: begin
            state_q  <= S_HUNT;
            synced_q <= 1'b0;
            lock_q   <= '0;
            tmo_q    <= '0;
          end
        endcase
      end
    end
  end

  assign rx.o_valid      = valid_q;
  assign rx.o_data       = data_q;
  assign rx.o_synced     = synced_q;
  assign rx.o_resync_req = resync_q;
  assign rx.o_err_count  = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_satalnk_rxsync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_satalnk_rxsync : scenario tasks with a forwarded-word scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_satalnk_rxsync;

  localparam logic [32:0] ALIGN = {1'b1, 32'h7B4A4ABC};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  satalnk_rxsync_if ifa ();
  satalnk_rxsync_if ifb ();

  satalnk_rxsync dut_a (.i_rx_clk(clk), .i_reset(rst), .rx(ifa));
  satalnk_rxsync #(.LG_TIMEOUT(4)) dut_b (.i_rx_clk(clk), .i_reset(rst), .rx(ifb));

  typedef struct {
    logic [32:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every forwarded word must match the oldest expectation, in the cycle it is due
  always @(negedge clk) begin
    exp_t e;
    if (ifa.o_valid === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL fwd_unexpected: o_data=%h forwarded, nothing expected (cyc %0d)", ifa.o_data, cyc);
      end else begin
        e = sb.pop_front();
        if (ifa.o_data !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL fwd_word: got %h at cyc %0d, want %h at cyc %0d", ifa.o_data, cyc, e.data, e.due);
        end
      end
    end
  end

  function automatic logic [32:0] rnd_word();
    logic [32:0] d;
    d = {1'($urandom_range(0, 1)), $urandom()};
    if (d == ALIGN) d[0] = ~d[0];
    return d;
  endfunction

  // Called at a falling edge; returns at the next falling edge with the word registered
  task automatic send_a(input logic [32:0] d, input logic err, input logic fwd);
    ifa.i_rx_valid    = 1'b1;
    ifa.i_rx_data     = d;
    ifa.i_rx_code_err = err;
    if (fwd) sb.push_back('{d, cyc + 1});
    @(negedge clk);
    ifa.i_rx_valid    = 1'b0;
    ifa.i_rx_code_err = 1'b0;
  endtask

  task automatic send_b(input logic [32:0] d);
    ifb.i_rx_valid = 1'b1;
    ifb.i_rx_data  = d;
    @(negedge clk);
    ifb.i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lock_a();
    repeat (4) send_a(ALIGN, 1'b0, 1'b0);
  endtask

  task automatic check_drained(input string tag);
    idle(2);
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d expected words never forwarded, want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    idle(2);
    n_chk++;
    if ({ifa.o_valid, ifa.o_data, ifa.o_synced, ifa.o_resync_req, ifa.o_err_count} !== 52'd0) begin
      n_err++;
      $display("FAIL reset_a: outputs=%h want 0",
               {ifa.o_valid, ifa.o_data, ifa.o_synced, ifa.o_resync_req, ifa.o_err_count});
    end
    n_chk++;
    if ({ifb.o_valid, ifb.o_data, ifb.o_synced, ifb.o_resync_req, ifb.o_err_count} !== 52'd0) begin
      n_err++;
      $display("FAIL reset_b: outputs=%h want 0",
               {ifb.o_valid, ifb.o_data, ifb.o_synced, ifb.o_resync_req, ifb.o_err_count});
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_lock();
    logic [32:0] w;
    for (int k = 0; k < 4; k++) begin
      send_a(ALIGN, 1'b0, 1'b0);
      n_chk++;
      if (ifa.o_synced !== (k == 3)) begin
        n_err++;
        $display("FAIL lock_synced_%0d: got %b want %b", k, ifa.o_synced, (k == 3));
      end
      for (int j = 0; j < 10; j++) begin
        w = rnd_word();
        send_a(w, 1'b0, k == 3);
        if (k == 3 && j == 0) begin
          n_chk++;
          if (ifa.o_valid !== 1'b1 || ifa.o_data !== w) begin
            n_err++;
            $display("FAIL lock_first_word: got v=%b d=%h want v=1 d=%h", ifa.o_valid, ifa.o_data, w);
          end
        end
      end
    end
    n_chk++;
    if (ifa.o_err_count !== 16'd0) begin
      n_err++;
      $display("FAIL lock_errcnt: got %0d want 0", ifa.o_err_count);
    end
    check_drained("lock");
  endtask

  task automatic test_err_loss();
    for (int e = 1; e <= 4; e++) begin
      repeat (5) send_a(rnd_word(), 1'b0, 1'b1);
      send_a(rnd_word(), 1'b1, 1'b0);
      n_chk++;
      if (ifa.o_synced !== (e < 4) || ifa.o_err_count !== 16'(e)) begin
        n_err++;
        $display("FAIL loss_err_%0d: got synced=%b cnt=%0d want synced=%b cnt=%0d",
                 e, ifa.o_synced, ifa.o_err_count, (e < 4), e);
      end
    end
    repeat (3) send_a(rnd_word(), 1'b0, 1'b0);
    n_chk++;
    if (ifa.o_synced !== 1'b0 || ifa.o_err_count !== 16'd4) begin
      n_err++;
      $display("FAIL loss_hold: got synced=%b cnt=%0d want synced=0 cnt=4", ifa.o_synced, ifa.o_err_count);
    end
    check_drained("loss");
  endtask

  task automatic test_err_clear();
    ifa.i_clr_errs = 1'b1;
    idle(1);
    ifa.i_clr_errs = 1'b0;
    n_chk++;
    if (ifa.o_err_count !== 16'd0) begin
      n_err++;
      $display("FAIL clr_idle: got %0d want 0", ifa.o_err_count);
    end
    lock_a();
    repeat (3) send_a(rnd_word(), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_a(rnd_word(), 1'b0, 1'b1);
    repeat (3) send_a(rnd_word(), 1'b1, 1'b0);
    n_chk++;
    if (ifa.o_synced !== 1'b1 || ifa.o_err_count !== 16'd6) begin
      n_err++;
      $display("FAIL good_clear: got synced=%b cnt=%0d want synced=1 cnt=6", ifa.o_synced, ifa.o_err_count);
    end
    check_drained("clear");
  endtask

  task automatic test_good_boundary();
    for (int i = 0; i < 15; i++) send_a(rnd_word(), 1'b0, 1'b1);
    n_chk++;
    if (ifa.o_synced !== 1'b1) begin
      n_err++;
      $display("FAIL good_15_synced: got %b want 1", ifa.o_synced);
    end
    send_a(rnd_word(), 1'b1, 1'b0);
    n_chk++;
    if (ifa.o_synced !== 1'b0 || ifa.o_err_count !== 16'd7) begin
      n_err++;
      $display("FAIL good_15_loss: got synced=%b cnt=%0d want synced=0 cnt=7", ifa.o_synced, ifa.o_err_count);
    end
    check_drained("boundary");
  endtask

  task automatic test_align_err();
    send_a(ALIGN, 1'b0, 1'b0);
    send_a(ALIGN, 1'b0, 1'b0);
    send_a(ALIGN, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_a(ALIGN, 1'b0, 1'b0);
      n_chk++;
      if (ifa.o_synced !== (k == 3)) begin
        n_err++;
        $display("FAIL align_err_relock_%0d: got synced=%b want %b", k, ifa.o_synced, (k == 3));
      end
    end
    repeat (3) send_a(rnd_word(), 1'b0, 1'b1);
    n_chk++;
    if (ifa.o_err_count !== 16'd7) begin
      n_err++;
      $display("FAIL align_err_cnt: got %0d want 7", ifa.o_err_count);
    end
    check_drained("align_err");
  endtask

  task automatic test_resync();
    int nv     = 0;
    int pulses = 0;
    logic want;
    while (nv < 48) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        n_chk++;
        if (ifb.o_resync_req !== 1'b0) begin
          n_err++;
          $display("FAIL resync_stall: got %b want 0 after %0d words", ifb.o_resync_req, nv);
        end
      end else begin
        send_b(rnd_word());
        nv++;
        want = (nv % 16 == 0);
        n_chk++;
        if (ifb.o_resync_req !== want || ifb.o_valid !== 1'b0) begin
          n_err++;
          $display("FAIL resync_word_%0d: got req=%b v=%b want req=%b v=0",
                   nv, ifb.o_resync_req, ifb.o_valid, want);
        end
        if (ifb.o_resync_req === 1'b1) begin
          pulses++;
          idle(1);
          n_chk++;
          if (ifb.o_resync_req !== 1'b0) begin
            n_err++;
            $display("FAIL resync_width: got %b want 0 one cycle after pulse", ifb.o_resync_req);
          end
        end
      end
    end
    n_chk++;
    if (pulses != 3) begin
      n_err++;
      $display("FAIL resync_pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_clr_reset();
    logic [32:0] w;
    ifa.i_clr_errs = 1'b1;
    idle(1);
    ifa.i_clr_errs = 1'b0;
    repeat (3) send_a(rnd_word(), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_a(rnd_word(), 1'b0, 1'b1);
    repeat (2) send_a(rnd_word(), 1'b1, 1'b0);
    n_chk++;
    if (ifa.o_synced !== 1'b1 || ifa.o_err_count !== 16'd5) begin
      n_err++;
      $display("FAIL clr_pre: got synced=%b cnt=%0d want synced=1 cnt=5", ifa.o_synced, ifa.o_err_count);
    end
    ifa.i_clr_errs = 1'b1;
    send_a(rnd_word(), 1'b1, 1'b0);
    ifa.i_clr_errs = 1'b0;
    n_chk++;
    if (ifa.o_synced !== 1'b1 || ifa.o_err_count !== 16'd0) begin
      n_err++;
      $display("FAIL clr_vs_err: got synced=%b cnt=%0d want synced=1 cnt=0", ifa.o_synced, ifa.o_err_count);
    end
    w = rnd_word();
    send_a(w, 1'b0, 1'b1);
    n_chk++;
    if (ifa.o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_valid: got %b want 1", ifa.o_valid);
    end
    ifa.i_rx_valid = 1'b1;
    ifa.i_rx_data  = rnd_word();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ifa.o_valid, ifa.o_data, ifa.o_synced, ifa.o_resync_req, ifa.o_err_count} !== 52'd0) begin
      n_err++;
      $display("FAIL rst_async: outputs=%h want 0",
               {ifa.o_valid, ifa.o_data, ifa.o_synced, ifa.o_resync_req, ifa.o_err_count});
    end
    ifa.i_rx_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
    send_a(ALIGN, 1'b0, 1'b0);
    repeat (2) send_a(rnd_word(), 1'b0, 1'b0);
    n_chk++;
    if (ifa.o_synced !== 1'b0) begin
      n_err++;
      $display("FAIL rst_hunt: got synced=%b want 0", ifa.o_synced);
    end
    check_drained("rst");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    ifa.i_rx_valid    = 1'b0;
    ifa.i_rx_data     = '0;
    ifa.i_rx_code_err = 1'b0;
    ifa.i_clr_errs    = 1'b0;
    ifb.i_rx_valid    = 1'b0;
    ifb.i_rx_data     = '0;
    ifb.i_rx_code_err = 1'b0;
    ifb.i_clr_errs    = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock();
    test_err_loss();
    test_err_clear();
    test_good_boundary();
    test_align_err();
    test_resync();
    test_clr_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
